// File: rtl/des_sbox_compress_pkg.sv
// Shared DES constants for the S-box compression stage: S-box and P tables,
// the controller state type, and the P permutation helper.
// DES numbers bits from the MSB, so DES bit n of a W-bit word is vector bit [W-1-n].
package des_pkg;

    localparam int DES_W_OUT = 32;
    localparam int DES_W_IN  = 48;
    localparam int CHUNK_W   = 6;
    localparam int NIB_W     = 4;

    // One 256-bit row-major word per S-box (S1 first). The leftmost nibble is row 0, column 0.
    localparam logic [255:0] SBOX [0:7] = '{
        256'hE4D12FB83A6C59070F74E2D1A6CB953841E8D62BFC973A50FC8249175BE3A06D,
        256'hF18E6B34972DC05A3D47F28EC01A69B50E7BA4D158C6932FD8A13F42B67C05E9,
        256'hA09E63F51DC7B428D709346A285ECBF1D6498F30B12C5AE71AD069874FE3B52C,
        256'h7DE3069A1285BC4FD8B56F03472C1AE9A690CB7DF13E52843F06A1D8945BC72E,
        256'h2C417AB6853FD0E9EB2C47D150FA3986421BAD78F9C5630EB8C71E2D6F09A453,
        256'hC1AF92680D34E75BAF427C9561DE0B389EF528C3704A1DB6432C95FABE17608D,
        256'h4B2EF08D3C975A61D0B7491AE35C2F8614BDC37EAF6805926BD814A7950FE23C,
        256'hD2846FB1A93E50C71FD8A374C56B0E927B419CE206ADF35821E74A8DFC90356B
    };

    // P permutation, 1-based source positions in DES bit order.
    localparam logic [5:0] P_TABLE [0:31] = '{
        6'd16, 6'd7,  6'd20, 6'd21, 6'd29, 6'd12, 6'd28, 6'd17,
        6'd1,  6'd15, 6'd23, 6'd26, 6'd5,  6'd18, 6'd31, 6'd10,
        6'd2,  6'd8,  6'd24, 6'd14, 6'd32, 6'd27, 6'd3,  6'd9,
        6'd19, 6'd13, 6'd30, 6'd6,  6'd22, 6'd11, 6'd4,  6'd25
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    // Table lookup: idx 0..7 selects S1..S8.
    function automatic logic [NIB_W-1:0] sbox_val(input logic [2:0] idx,
                                                  input logic [1:0] row,
                                                  input logic [3:0] col);
        logic [255:0] tbl;
        tbl = SBOX[idx];
        return tbl[255 - NIB_W * int'({row, col}) -: NIB_W];
    endfunction

    // DES P permutation: output DES bit i takes input DES bit P_TABLE[i]-1.
    function automatic logic [DES_W_OUT-1:0] p_perm(input logic [DES_W_OUT-1:0] x);
        logic [DES_W_OUT-1:0] res;
        res = '0;
        for (int i = 0; i < DES_W_OUT; i++) begin
            res[DES_W_OUT-1-i] = x[DES_W_OUT - int'(P_TABLE[i])];
        end
        return res;
    endfunction

endpackage

// File: rtl/des_sbox_compress_if.sv
// Valid/ready bus of the S-box compression stage: producer side (in_*),
// consumer side (out_*) and the busy status flag.
interface des_sbox_compress_if;
    import des_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic [DES_W_IN-1:0]  in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [DES_W_OUT-1:0] out_data;
    logic                 busy;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, busy
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

endinterface

// File: rtl/des_sbox_compress_lookup.sv
// One DES S-box: the outer chunk bits select the row, the inner four select the column.
module des_sbox_lookup
    import des_pkg::*;
(
    input  logic [2:0]         sel,
    input  logic [CHUNK_W-1:0] chunk,
    output logic [NIB_W-1:0]   nibble
);

    // Row = {DES bit 0, DES bit 5}, column = DES bits 1..4.
    always_comb begin
        nibble = sbox_val(sel, {chunk[5], chunk[0]}, chunk[4:1]);
    end

endmodule

// File: rtl/des_sbox_compress.sv
// Iterative S1..S8 + P compression of the DES f function. SBOX_PER_CYCLE
// S-boxes are evaluated per clock, so one word takes 8/SBOX_PER_CYCLE clocks.
module des_sbox_compress
    import des_pkg::*;
#(
    parameter int SBOX_PER_CYCLE = 1
) (
    input  logic               clk,
    input  logic               n_rst,
    des_sbox_compress_if.slave bus
);

    localparam int NUM_STEPS = 8 / SBOX_PER_CYCLE;

    generate
        if (!(SBOX_PER_CYCLE == 1 || SBOX_PER_CYCLE == 2 ||
              SBOX_PER_CYCLE == 4 || SBOX_PER_CYCLE == 8)) begin : g_bad_param
            $error("des_sbox_compress: SBOX_PER_CYCLE must be 1, 2, 4 or 8");
        end
    endgenerate

    state_e               state_q, state_d;
    logic [DES_W_IN-1:0]  data_q, data_d;
    logic [2:0]           step_q, step_d;
    logic [DES_W_OUT-1:0] acc_q, acc_d;
    logic [DES_W_OUT-1:0] out_q, out_d;
    logic [DES_W_OUT-1:0] acc_upd_s;
    logic                 in_ready_s;
    logic                 last_step_s;
    logic [2:0]           sel_s [SBOX_PER_CYCLE];
    logic [NIB_W-1:0]     nib_s [SBOX_PER_CYCLE];

    for (genvar j = 0; j < SBOX_PER_CYCLE; j++) begin : g_lut
        assign sel_s[j] = 3'(int'(step_q) * SBOX_PER_CYCLE + j);

        des_sbox_lookup u_lut (
            .sel    (sel_s[j]),
            .chunk  (data_q[DES_W_IN-1 - CHUNK_W*int'(sel_s[j]) -: CHUNK_W]),
            .nibble (nib_s[j])
        );
    end

    assign last_step_s = (step_q == 3'(NUM_STEPS - 1));

    // Merge this step's nibbles into the accumulator at their DES positions.
    always_comb begin
        acc_upd_s = acc_q;
        for (int j = 0; j < SBOX_PER_CYCLE; j++) begin
            acc_upd_s[DES_W_OUT-1 - NIB_W*int'(sel_s[j]) -: NIB_W] = nib_s[j];
        end
    end

    // Controller next state: capture in IDLE (or DONE on handshake), iterate in BUSY.
    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        step_d     = step_q;
        acc_d      = acc_q;
        out_d      = out_q;
        in_ready_s = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready_s = 1'b1;
                if (bus.in_valid) begin
                    data_d  = bus.in_data;
                    step_d  = 3'd0;
                    acc_d   = '0;
                    state_d = BUSY;
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                acc_d = acc_upd_s;
                if (last_step_s) begin
                    out_d   = p_perm(acc_upd_s);
                    step_d  = 3'd0;
                    state_d = DONE;
                end else begin
                    step_d  = step_q + 3'd1;
                end
            end
            DONE: begin
                // A new word can only enter on the same edge the result leaves.
                in_ready_s = bus.out_ready;
                if (bus.out_ready && bus.in_valid) begin
                    data_d  = bus.in_data;
                    step_d  = 3'd0;
                    acc_d   = '0;
                    state_d = BUSY;
                end else if (bus.out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, capture, step, accumulator and result registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            step_q  <= 3'd0;
            acc_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            step_q  <= step_d;
            acc_q   <= acc_d;
            out_q   <= out_d;
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q == BUSY);
    assign bus.out_data  = out_q;

endmodule

// File: tb/tb_des_sbox_compress.sv
// Self-checking bench for des_sbox_compress: directed FIPS/corner cases plus a
// scoreboarded random soak against a table-driven DES compression model.
module tb_des_sbox_compress;

    logic clk;
    logic n_rst;
    int   checks = 0;
    int   errors = 0;

    localparam logic [47:0] FIPS_IN  = 48'h6117BA866527;
    localparam logic [31:0] FIPS_OUT = 32'h234AA9BB;

    // Model tables written straight from FIPS 46-3 (row-major, row 0 col 0 leftmost).
    localparam logic [255:0] TB_SB [8] = '{
        256'hE4D12FB83A6C59070F74E2D1A6CB953841E8D62BFC973A50FC8249175BE3A06D,
        256'hF18E6B34972DC05A3D47F28EC01A69B50E7BA4D158C6932FD8A13F42B67C05E9,
        256'hA09E63F51DC7B428D709346A285ECBF1D6498F30B12C5AE71AD069874FE3B52C,
        256'h7DE3069A1285BC4FD8B56F03472C1AE9A690CB7DF13E52843F06A1D8945BC72E,
        256'h2C417AB6853FD0E9EB2C47D150FA3986421BAD78F9C5630EB8C71E2D6F09A453,
        256'hC1AF92680D34E75BAF427C9561DE0B389EF528C3704A1DB6432C95FABE17608D,
        256'h4B2EF08D3C975A61D0B7491AE35C2F8614BDC37EAF6805926BD814A7950FE23C,
        256'hD2846FB1A93E50C71FD8A374C56B0E927B419CE206ADF35821E74A8DFC90356B
    };
    localparam int TB_P [32] = '{16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
                                 2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};

    des_sbox_compress_if b1 ();
    des_sbox_compress_if b2 ();
    des_sbox_compress_if b4 ();
    des_sbox_compress_if b8 ();

    des_sbox_compress #(.SBOX_PER_CYCLE(1)) u_dut1 (.clk(clk), .n_rst(n_rst), .bus(b1));
    des_sbox_compress #(.SBOX_PER_CYCLE(2)) u_dut2 (.clk(clk), .n_rst(n_rst), .bus(b2));
    des_sbox_compress #(.SBOX_PER_CYCLE(4)) u_dut4 (.clk(clk), .n_rst(n_rst), .bus(b4));
    des_sbox_compress #(.SBOX_PER_CYCLE(8)) u_dut8 (.clk(clk), .n_rst(n_rst), .bus(b8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference f-compression: S-box lookups by arithmetic, then P by table.
    function automatic logic [31:0] ref_f(input logic [47:0] x);
        logic [31:0] s;
        logic [31:0] p;
        int c, row, col;
        s = 32'h0;
        for (int i = 0; i < 8; i++) begin
            c   = int'((x >> (42 - 6 * i)) & 48'h3F);
            row = (c / 32) * 2 + (c % 2);
            col = (c / 2) % 16;
            s   = (s << 4) | 32'((TB_SB[i] >> (4 * (63 - (row * 16 + col)))) & 256'hF);
        end
        p = 32'h0;
        for (int i = 0; i < 32; i++) p[31 - i] = s[32 - TB_P[i]];
        return p;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drv(input int w, input logic v, input logic [47:0] d, input logic r);
        case (w)
            2:       begin b2.in_valid = v; b2.in_data = d; b2.out_ready = r; end
            4:       begin b4.in_valid = v; b4.in_data = d; b4.out_ready = r; end
            8:       begin b8.in_valid = v; b8.in_data = d; b8.out_ready = r; end
            default: begin b1.in_valid = v; b1.in_data = d; b1.out_ready = r; end
        endcase
    endtask

    task automatic smp(input int w, output logic ir, output logic ov,
                       output logic [31:0] od, output logic bz);
        case (w)
            2:       begin ir = b2.in_ready; ov = b2.out_valid; od = b2.out_data; bz = b2.busy; end
            4:       begin ir = b4.in_ready; ov = b4.out_valid; od = b4.out_data; bz = b4.busy; end
            8:       begin ir = b8.in_ready; ov = b8.out_valid; od = b8.out_data; bz = b8.busy; end
            default: begin ir = b1.in_ready; ov = b1.out_valid; od = b1.out_data; bz = b1.busy; end
        endcase
    endtask

    // Called on the negedge right after the capture edge; counts clocks until out_valid.
    task automatic wait_out(input int w, output int lat, output logic [31:0] od);
        logic ir, ov, bz;
        lat = 0;
        smp(w, ir, ov, od, bz);
        while (!ov && lat < 40) begin
            @(negedge clk);
            lat++;
            smp(w, ir, ov, od, bz);
        end
    endtask

    // Send one word, check acceptance, latency and result, then drain it.
    task automatic run_word(input int w, input logic [47:0] word,
                            input logic [31:0] exp, input string tag);
        logic ir, ov, bz;
        logic [31:0] od;
        int lat;
        @(negedge clk);
        drv(w, 1'b1, word, 1'b0);
        #1 smp(w, ir, ov, od, bz);
        chk({tag, "_in_ready"}, 64'(ir), 64'd1);
        @(negedge clk);
        drv(w, 1'b0, 48'h0, 1'b0);
        smp(w, ir, ov, od, bz);
        chk({tag, "_busy"}, 64'(bz), 64'd1);
        chk({tag, "_no_early_valid"}, 64'(ov), 64'd0);
        wait_out(w, lat, od);
        chk({tag, "_latency"}, 64'(lat), 64'(8 / w));
        chk({tag, "_data"}, 64'(od), 64'(exp));
        drv(w, 1'b0, 48'h0, 1'b1);
        @(negedge clk);
        drv(w, 1'b0, 48'h0, 1'b0);
        smp(w, ir, ov, od, bz);
        chk({tag, "_drained"}, 64'(ov), 64'd0);
    endtask

    // Random producer/consumer gaps with an in-order scoreboard.
    task automatic soak(input int w, input int nwords);
        logic [31:0] exq [$];
        logic v, r, ir, ov, bz;
        logic [47:0] d;
        logic [31:0] od;
        int sent, recv, cyc;
        v = 1'b0; d = 48'h0; sent = 0; recv = 0; cyc = 0;
        while (recv < nwords && cyc < nwords * 30) begin
            r = ($urandom_range(0, 3) != 0);
            if (!v && sent < nwords && $urandom_range(0, 3) != 0) begin
                v = 1'b1;
                d = {16'($urandom), $urandom};
            end
            drv(w, v, d, r);
            #1 smp(w, ir, ov, od, bz);
            if (ov && r) begin
                chk("soak_expected_pending", 64'(exq.size() != 0), 64'd1);
                if (exq.size() != 0) chk("soak_data", 64'(od), 64'(exq.pop_front()));
                recv++;
            end
            if (v && ir) begin
                exq.push_back(ref_f(d));
                sent++;
                v = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        chk("soak_received", 64'(recv), 64'(nwords));
        chk("soak_leftover", 64'(exq.size()), 64'd0);
        drv(w, 1'b0, 48'h0, 1'b0);
    endtask

    initial begin
        logic ir, ov, bz;
        logic [31:0] od;
        logic [31:0] ex;
        logic [47:0] wd;
        int lat;

        for (int w = 1; w <= 8; w = w * 2) drv(w, 1'b0, 48'h0, 1'b0);
        n_rst = 1'b0;
        repeat (3) @(negedge clk);
        smp(1, ir, ov, od, bz);
        chk("reset_in_ready", 64'(ir), 64'd1);
        chk("reset_out_valid", 64'(ov), 64'd0);
        chk("reset_busy", 64'(bz), 64'd0);
        chk("reset_out_data", 64'(od), 64'd0);
        n_rst = 1'b1;

        // FIPS worked example, then all-zero input on every legal width.
        run_word(1, FIPS_IN, FIPS_OUT, "fips");
        for (int w = 1; w <= 8; w = w * 2) run_word(w, 48'h0, ref_f(48'h0), $sformatf("zero_w%0d", w));
        run_word(8, FIPS_IN, FIPS_OUT, "fips_w8");

        // Backpressure: result held for 20 clocks while in_valid toggles.
        wd = {16'($urandom), $urandom};
        ex = ref_f(wd);
        @(negedge clk);
        drv(1, 1'b1, wd, 1'b0);
        @(negedge clk);
        drv(1, 1'b0, 48'h0, 1'b0);
        wait_out(1, lat, od);
        chk("bp_latency", 64'(lat), 64'd8);
        for (int i = 0; i < 20; i++) begin
            drv(1, (i % 2) == 1, {16'($urandom), $urandom}, 1'b0);
            #1 smp(1, ir, ov, od, bz);
            chk("bp_out_data", 64'(od), 64'(ex));
            chk("bp_out_valid", 64'(ov), 64'd1);
            chk("bp_in_ready", 64'(ir), 64'd0);
            @(negedge clk);
        end
        drv(1, 1'b0, 48'h0, 1'b1);
        @(negedge clk);
        drv(1, 1'b0, 48'h0, 1'b0);
        smp(1, ir, ov, od, bz);
        chk("bp_release_valid", 64'(ov), 64'd0);
        chk("bp_release_idle", 64'(ir), 64'd1);
        chk("bp_release_busy", 64'(bz), 64'd0);

        // Back-to-back: second word captured on the same edge the first leaves.
        wd = {16'($urandom), $urandom};
        @(negedge clk);
        drv(1, 1'b1, wd, 1'b0);
        @(negedge clk);
        drv(1, 1'b0, 48'h0, 1'b0);
        wait_out(1, lat, od);
        chk("b2b_first_latency", 64'(lat), 64'd8);
        drv(1, 1'b1, 48'hFFFFFFFFFFFF, 1'b1);
        #1 smp(1, ir, ov, od, bz);
        chk("b2b_in_ready", 64'(ir), 64'd1);
        chk("b2b_first_data", 64'(od), 64'(ref_f(wd)));
        @(negedge clk);
        drv(1, 1'b0, 48'h0, 1'b0);
        smp(1, ir, ov, od, bz);
        chk("b2b_no_bubble_busy", 64'(bz), 64'd1);
        chk("b2b_valid_dropped", 64'(ov), 64'd0);
        wait_out(1, lat, od);
        chk("b2b_second_latency", 64'(lat), 64'd8);
        chk("b2b_second_data", 64'(od), 64'(ref_f(48'hFFFFFFFFFFFF)));
        drv(1, 1'b0, 48'h0, 1'b1);
        @(negedge clk);
        drv(1, 1'b0, 48'h0, 1'b0);

        // Reset while the single-S-box instance sits at step 3.
        @(negedge clk);
        drv(1, 1'b1, FIPS_IN, 1'b0);
        @(negedge clk);
        drv(1, 1'b0, 48'h0, 1'b0);
        repeat (3) @(negedge clk);
        smp(1, ir, ov, od, bz);
        chk("rst_mid_was_busy", 64'(bz), 64'd1);
        n_rst = 1'b0;
        #1 smp(1, ir, ov, od, bz);
        chk("rst_mid_out_valid", 64'(ov), 64'd0);
        chk("rst_mid_out_data", 64'(od), 64'd0);
        chk("rst_mid_busy", 64'(bz), 64'd0);
        chk("rst_mid_in_ready", 64'(ir), 64'd1);
        @(negedge clk);
        n_rst = 1'b1;
        run_word(1, FIPS_IN, FIPS_OUT, "rst_rerun");

        // Random soak: full 10k words on the widest instance, a shorter run on the narrowest.
        soak(8, 10000);
        soak(1, 500);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
